// File: rtl/serial_tx_if.sv
// Parallel-load / serial-line handshake bundle for the serial_tx frame transmitter.
interface serial_tx_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] d_in;
  logic                  load;
  logic                  ready_out;
  logic                  busy_out;
  logic                  tx_out;
  logic                  done_out;

  modport master (
    output d_in, load,
    input  ready_out, busy_out, tx_out, done_out
  );

  modport slave (
    input  d_in, load,
    output ready_out, busy_out, tx_out, done_out
  );
endinterface

// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit (0), DATA_WIDTH bits LSB-first,
// stop bit (1), each bit held CLKS_PER_BIT clocks. All outputs are registered.
module serial_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input logic        clk,
  input logic        rst,
  serial_tx_if.slave bus
);
  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] INDEX_LAST = IW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_nxt;
  logic [TW-1:0]         timer, timer_nxt;
  logic [IW-1:0]         index, index_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic                  tx_q, tx_nxt;
  logic                  ready_q, ready_nxt;
  logic                  busy_q, busy_nxt;
  logic                  done_q, done_nxt;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      index   <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      index   <= index_nxt;
      shreg   <= shreg_nxt;
      tx_q    <= tx_nxt;
      ready_q <= ready_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  // Next state; outputs are derived from the next state so they register in step with it
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    index_nxt = index;
    shreg_nxt = shreg;
    done_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.load) begin
          shreg_nxt = bus.d_in;
          timer_nxt = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (timer == TIMER_LAST) begin
          timer_nxt = '0;
          index_nxt = '0;
          state_nxt = DATA;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      DATA: begin
        if (timer == TIMER_LAST) begin
          timer_nxt = '0;
          if (index == INDEX_LAST) begin
            state_nxt = STOP;
          end else begin
            index_nxt = index + IW'(1);
          end
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      STOP: begin
        if (timer == TIMER_LAST) begin
          timer_nxt = '0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    unique case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[index_nxt];
      default: tx_nxt = 1'b1;
    endcase
    ready_nxt = (state_nxt == IDLE);
    busy_nxt  = (state_nxt != IDLE);
  end

  assign bus.tx_out    = tx_q;
  assign bus.ready_out = ready_q;
  assign bus.busy_out  = busy_q;
  assign bus.done_out  = done_q;
endmodule
